// File: rtl/rp_reconfig_ctrl.sv
// rp_reconfig_ctrl: partial-reconfiguration sequencer (reset, wait-active, run, shutdown, load).
// Optional shutdown-ack timeout enabled by defining RP_SHUTDOWN_TIMEOUT_EN.
module rp_reconfig_ctrl #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RESET_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reconf_req,
  input  logic       reconf_done,
  output logic       shutdown_req,
  input  logic       shutdown_ack,
  input  logic       rp_active,
  output logic       decouple,
  output logic       rst_prc_n,
  output logic       reconf_ready,
  output logic       timeout_flag,
  output logic [2:0] state
);
  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_SHUT  = 3'd3;
  localparam logic [2:0] S_LOAD  = 3'd4;
  localparam int RW = $clog2(RESET_CYCLES + 1);
  logic [1:0]    sync_q, sync_d;
  logic [2:0]    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          decouple_q, decouple_d;
  logic          rst_prc_n_q, rst_prc_n_d;
  logic          shutdown_req_q, shutdown_req_d;
  logic          reconf_ready_q, reconf_ready_d;
`ifdef RP_SHUTDOWN_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          tflag_q, tflag_d;
  logic          tmo;
  assign tmo = wcnt_q >= WW'(TIMEOUT_CYCLES - 1);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif
  always_comb begin
    sync_d  = {sync_q[0], 1'b1};
    state_d = S_RESET;
    rcnt_d  = '0;
`ifdef RP_SHUTDOWN_TIMEOUT_EN
    wcnt_d  = '0;
    tflag_d = tflag_q;
`endif
    case (state_q)
      S_RESET: begin
        rcnt_d  = !sync_q[1] ? '0 : (rcnt_q == RW'(RESET_CYCLES)) ? rcnt_q : rcnt_q + RW'(1);
        state_d = (sync_q[1] && rcnt_q >= RW'(RESET_CYCLES - 1)) ? S_WAIT : S_RESET;
      end
      S_WAIT: state_d = rp_active ? S_RUN : S_WAIT;
      S_RUN: begin
        state_d = reconf_req ? S_SHUT : S_RUN;
`ifdef RP_SHUTDOWN_TIMEOUT_EN
        tflag_d = reconf_req ? 1'b0 : tflag_q;
`endif
      end
      S_SHUT: begin
`ifdef RP_SHUTDOWN_TIMEOUT_EN
        wcnt_d  = (wcnt_q == '1) ? wcnt_q : wcnt_q + WW'(1);
        state_d = (shutdown_ack || tmo) ? S_LOAD : S_SHUT;
        tflag_d = (!shutdown_ack && tmo) ? 1'b1 : tflag_q;
`else
        state_d = shutdown_ack ? S_LOAD : S_SHUT;
`endif
      end
      S_LOAD:  state_d = reconf_done ? S_RESET : S_LOAD;
      default: state_d = S_RESET;
    endcase
    decouple_d     = state_d != S_RUN;
    rst_prc_n_d    = !(state_d == S_RESET || state_d == S_LOAD);
    shutdown_req_d = state_d == S_SHUT;
    reconf_ready_d = state_d == S_LOAD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q         <= '0;
      state_q        <= S_RESET;
      rcnt_q         <= '0;
      decouple_q     <= 1'b1;
      rst_prc_n_q    <= 1'b0;
      shutdown_req_q <= 1'b0;
      reconf_ready_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      rcnt_q         <= rcnt_d;
      decouple_q     <= decouple_d;
      rst_prc_n_q    <= rst_prc_n_d;
      shutdown_req_q <= shutdown_req_d;
      reconf_ready_q <= reconf_ready_d;
    end
  end
`ifdef RP_SHUTDOWN_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q  <= '0;
      tflag_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      tflag_q <= tflag_d;
    end
  end
  assign timeout_flag = tflag_q;
`else
  assign timeout_flag = 1'b0;
`endif
  assign state        = state_q;
  assign decouple     = decouple_q;
  assign rst_prc_n    = rst_prc_n_q;
  assign shutdown_req = shutdown_req_q;
  assign reconf_ready = reconf_ready_q;
endmodule

// File: tb/tb_rp_reconfig_ctrl.sv
// tb_rp_reconfig_ctrl: directed sequence with an expected-output queue for rp_reconfig_ctrl.
module tb_rp_reconfig_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reconf_req = 1'b0;
  logic reconf_done = 1'b0;
  logic shutdown_ack = 1'b0;
  logic rp_active = 1'b0;
  logic shutdown_req, decouple, rst_prc_n, reconf_ready, timeout_flag;
  logic [2:0] state;
  logic [7:0] obs;
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  rp_reconfig_ctrl #(.TIMEOUT_CYCLES(100), .RESET_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .reconf_req(reconf_req), .reconf_done(reconf_done),
    .shutdown_req(shutdown_req), .shutdown_ack(shutdown_ack), .rp_active(rp_active),
    .decouple(decouple), .rst_prc_n(rst_prc_n), .reconf_ready(reconf_ready),
    .timeout_flag(timeout_flag), .state(state)
  );
  assign obs = {state, decouple, rst_prc_n, shutdown_req, reconf_ready, timeout_flag};
  function automatic logic [7:0] mv(logic [2:0] st, logic tf);
    return {st, st != 3'd2, !(st == 3'd0 || st == 3'd4), st == 3'd3, st == 3'd4, tf};
  endfunction
  task automatic chk(string tag, logic [7:0] o, logic [7:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask
  task automatic run(string tag, int n, logic [2:0] st, logic tf);
    repeat (n) begin
      exp_q.push_back(mv(st, tf));
      @(posedge clk);
      #1;
      chk(tag, obs, exp_q.pop_front());
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", obs, mv(3'd0, 1'b0));
    rst = 1'b0;
    run("rst_count", 17, 3'd0, 1'b0);
    run("wait_active", 13, 3'd1, 1'b0);
    rp_active = 1'b1;
    run("to_run", 1, 3'd2, 1'b0);
    rp_active = 1'b0;
    reconf_done = 1'b1;
    shutdown_ack = 1'b1;
    run("run_ignore", 3, 3'd2, 1'b0);
    reconf_done = 1'b0;
    shutdown_ack = 1'b0;
    rp_active = 1'b1;
    reconf_req = 1'b1;
    run("shutdown", 5, 3'd3, 1'b0);
    shutdown_ack = 1'b1;
    run("loading", 1, 3'd4, 1'b0);
    shutdown_ack = 1'b0;
    run("loading_hold", 3, 3'd4, 1'b0);
    reconf_done = 1'b1;
    run("done", 1, 3'd0, 1'b0);
    reconf_done = 1'b0;
    reconf_req = 1'b0;
    run("reload", 15, 3'd0, 1'b0);
    run("rewait", 1, 3'd1, 1'b0);
    run("rerun", 1, 3'd2, 1'b0);
    reconf_req = 1'b1;
    run("to_enter", 1, 3'd3, 1'b0);
    reconf_req = 1'b0;
`ifdef RP_SHUTDOWN_TIMEOUT_EN
    run("to_wait", 99, 3'd3, 1'b0);
    run("to_fire", 1, 3'd4, 1'b1);
    run("to_sticky", 2, 3'd4, 1'b1);
    reconf_done = 1'b1;
    run("to_done", 1, 3'd0, 1'b1);
    reconf_done = 1'b0;
    run("to_reload", 15, 3'd0, 1'b1);
    run("to_rewait", 1, 3'd1, 1'b1);
    run("to_rerun", 1, 3'd2, 1'b1);
    reconf_req = 1'b1;
    run("tf_clear", 1, 3'd3, 1'b0);
    reconf_req = 1'b0;
    run("tie_wait", 99, 3'd3, 1'b0);
    shutdown_ack = 1'b1;
    run("ack_wins", 1, 3'd4, 1'b0);
`else
    run("no_timeout", 999, 3'd3, 1'b0);
    shutdown_ack = 1'b1;
    run("late_ack", 1, 3'd4, 1'b0);
`endif
    shutdown_ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", obs, mv(3'd0, 1'b0));
    #1;
    rst = 1'b0;
    run("post_rst", 17, 3'd0, 1'b0);
    run("post_wait", 1, 3'd1, 1'b0);
    run("post_run", 1, 3'd2, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rp_reconfig_ctrl.md
RP_RECONFIG_CTRL -- requirements
Module: rp_reconfig_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65536: shutdown-ack wait limit in clk cycles; range 2..2^24.
REQ-002 Parameter RESET_CYCLES, default 16: rst_prc_n low time after load; range 1..255.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 reconf_req  in  1  host request to start partition reconfiguration; level, sampled in RUN only.
REQ-006 reconf_done  in  1  bitstream load complete; sampled in LOADING only.
REQ-007 shutdown_req  out  1  to partition: request quiesce.
REQ-008 shutdown_ack  in  1  from partition: quiesced.
REQ-009 rp_active  in  1  from partition: partition operational.
REQ-010 decouple  out  1  isolates partition AXI/AXIS/irq from static logic when high.
REQ-011 rst_prc_n  out  1  partition reset, active-low.
REQ-012 reconf_ready  out  1  safe to load bitstream.
REQ-013 timeout_flag  out  1  sticky: last shutdown ended by timeout.
REQ-014 state  out  3  current FSM encoding, for status register.

Function
REQ-015 FSM states and encodings: RESET=0, WAIT_ACTIVE=1, RUN=2, SHUTDOWN=3, LOADING=4; other codes unreachable and decode to RESET.
REQ-016 Outputs registered, Moore-decoded from state: decouple=1 in all states except RUN; rst_prc_n=0 in RESET and LOADING, else 1; shutdown_req=1 only in SHUTDOWN; reconf_ready=1 only in LOADING.
REQ-017 RESET: count RESET_CYCLES cycles, then WAIT_ACTIVE.
REQ-018 WAIT_ACTIVE: rp_active=1 -> RUN next cycle; no timeout.
REQ-019 RUN: reconf_req=1 -> SHUTDOWN next cycle, so shutdown_req rises 1 cycle after reconf_req sampled; timeout_flag cleared on this transition.
REQ-020 SHUTDOWN: shutdown_ack=1 -> LOADING next cycle; wait counter starts at 0 on entry and increments each cycle.
REQ-021 LOADING: reconf_done=1 -> RESET next cycle; RESET counter reloads on entry.
REQ-022 reconf_req outside RUN, reconf_done outside LOADING, shutdown_ack outside SHUTDOWN: ignored, no queuing.
REQ-023 rp_active deasserting in RUN: no state change.
REQ-024 Counters saturate, never wrap; widths sized from parameters via clog2.

Reset
REQ-025 rst asserted: state=RESET, counters 0, timeout_flag=0, decouple=1, rst_prc_n=0, shutdown_req=0, reconf_ready=0, taking effect immediately without a clock edge.
REQ-026 rst asserted mid-operation (any state): same as REQ-025; partition stays decoupled until RUN is reached again.
REQ-027 rst deassertion synchronised internally through 2 flops; FSM leaves RESET no earlier than RESET_CYCLES + 2 cycles after deassertion.

Configuration
REQ-028 Macro RP_SHUTDOWN_TIMEOUT_EN defined: in SHUTDOWN, wait count reaching TIMEOUT_CYCLES without ack -> LOADING next cycle and timeout_flag=1.
REQ-029 Ack and timeout in the same cycle: ack wins, timeout_flag stays 0.
REQ-030 Macro undefined: no wait counter; SHUTDOWN exits only on shutdown_ack; timeout_flag tied 0.

Verification
REQ-031 Release rst, RESET_CYCLES=16, rp_active=1 at cycle 30 -> state RESET→WAIT_ACTIVE→RUN; decouple falls at cycle 31; rst_prc_n high from cycle 18.
REQ-032 In RUN, reconf_req=1 at cycle N, shutdown_ack at N+5 -> shutdown_req high N+1..N+5; reconf_ready and decouple high from N+6; rst_prc_n low from N+6.
REQ-033 In LOADING, reconf_done pulse, rp_active=1 -> rst_prc_n low exactly 16 cycles, then WAIT_ACTIVE, then RUN; timeout_flag=0.
REQ-034 RP_SHUTDOWN_TIMEOUT_EN, TIMEOUT_CYCLES=100, no ack -> LOADING after 100 cycles in SHUTDOWN, timeout_flag=1 until next accepted reconf_req; macro undefined -> SHUTDOWN held after 1000 cycles.
REQ-035 rst pulse while in LOADING -> decouple=1, rst_prc_n=0, reconf_ready=0 before next clk edge; state=0.
REQ-036 reconf_done pulsed in RUN and reconf_req held through SHUTDOWN/LOADING -> no spurious transitions; exactly one reconfiguration cycle per acceptance in RUN.
